// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port BRAM (1-cycle read latency) between a
// text-mode display fetcher and a CPU. The display side is served from a
// one-entry word cache; a miss competes with CPU accesses for the BRAM port.
// Display misses normally win. Defining VRAM_ARB_STARVE_GUARD_EN adds a
// saturating counter that hands the port to a waiting CPU after STARVE_MAX
// consecutive display grants.
module vram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LANE_W = DATA_W / 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] tag_r;
    logic              tag_valid_r;
    logic [DATA_W-1:0] cache_data_r;
    logic              txn_disp_r;   // in-flight transaction belongs to the display
    logic              txn_we_r;     // in-flight transaction is a CPU write

    logic              hit_s;
    logic              miss_s;
    logic              cpu_ok_s;
    logic              grant_disp_s;
    logic              grant_cpu_s;

    // Merge the strobed byte lanes of new_word over old_word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [3:0]        strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
            end else begin
                res[i*LANE_W +: LANE_W] = old_word[i*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

    assign hit_s      = tag_valid_r & (tag_r == disp_addr);
    assign disp_valid = hit_s;
    assign disp_data  = cache_data_r;
    assign miss_s     = disp_req & ~hit_s;
    // While cpu_ack is high the requester still presents the finished request.
    assign cpu_ok_s   = cpu_req & ~cpu_ack;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             starve_hit_s;

    assign starve_hit_s = (starve_cnt_r == CNT_W'(STARVE_MAX));

    // Pick the IDLE winner; a starved CPU pre-empts the display.
    always_comb begin
        grant_disp_s = 1'b0;
        grant_cpu_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (cpu_ok_s && starve_hit_s) begin
                grant_cpu_s = 1'b1;
            end else if (miss_s) begin
                grant_disp_s = 1'b1;
            end else if (cpu_ok_s) begin
                grant_cpu_s = 1'b1;
            end else begin
                grant_disp_s = 1'b0;
            end
        end else begin
            grant_cpu_s = 1'b0;
        end
    end

    // Count display grants taken while the CPU waits; saturate, clear on CPU grant.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_cpu_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_disp_s && cpu_req && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    // Pick the IDLE winner; display misses have strict priority.
    always_comb begin
        grant_disp_s = 1'b0;
        grant_cpu_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (miss_s) begin
                grant_disp_s = 1'b1;
            end else if (cpu_ok_s) begin
                grant_cpu_s = 1'b1;
            end else begin
                grant_disp_s = 1'b0;
            end
        end else begin
            grant_cpu_s = 1'b0;
        end
    end
`endif

    // Transaction sequencer: drives the BRAM port, fills the cache, acks the CPU.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r      <= ST_IDLE;
            tag_r        <= {ADDR_W{1'b0}};
            tag_valid_r  <= 1'b0;
            cache_data_r <= {DATA_W{1'b0}};
            txn_disp_r   <= 1'b0;
            txn_we_r     <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= {DATA_W{1'b0}};
            mem_en       <= 1'b0;
            mem_we       <= 4'b0000;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
        end else begin
            // Strobes are single-cycle unless a branch below asserts them.
            cpu_ack <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 4'b0000;
            case (state_r)
                ST_IDLE: begin
                    if (grant_disp_s) begin
                        state_r    <= ST_ACCESS;
                        mem_en     <= 1'b1;
                        mem_addr   <= disp_addr;
                        txn_disp_r <= 1'b1;
                        txn_we_r   <= 1'b0;
                    end else if (grant_cpu_s) begin
                        state_r    <= ST_ACCESS;
                        mem_en     <= 1'b1;
                        mem_we     <= cpu_we ? cpu_wstrb : 4'b0000;
                        mem_addr   <= cpu_addr;
                        mem_wdata  <= cpu_we ? cpu_wdata : mem_wdata;
                        txn_disp_r <= 1'b0;
                        txn_we_r   <= cpu_we;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (txn_we_r) begin
                        // Write lands in BRAM at this edge; keep the cached copy coherent.
                        state_r <= ST_IDLE;
                        cpu_ack <= 1'b1;
                        if (tag_valid_r && (tag_r == mem_addr)) begin
                            cache_data_r <= merge_bytes(cache_data_r, mem_wdata, mem_we);
                        end else begin
                            cache_data_r <= cache_data_r;
                        end
                    end else begin
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state_r <= ST_IDLE;
                    if (txn_disp_r) begin
                        tag_r        <= mem_addr;
                        cache_data_r <= mem_rdata;
                        tag_valid_r  <= 1'b1;
                    end else begin
                        cpu_rdata <= mem_rdata;
                        cpu_ack   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural 2048x32
// BRAM (1-cycle read latency, byte write enables). Builds with or without
// VRAM_ARB_STARVE_GUARD_EN; the arbitration expectations follow the macro.
module tb_vram_arbiter;

    logic        clk;
    logic        axi_aresetn;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:2047];

    int n_checks;
    int n_fail;

    vram_arbiter #(
        .ADDR_W(11),
        .DATA_W(32),
        .STARVE_MAX(8)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(axi_aresetn),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wstrb  (cpu_wstrb),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: preload, then read-before-write on every enabled edge.
    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 32'h5A000000 | 32'(i);
        end
        mem[5]    = 32'h41424344;
        mem[7]    = 32'hDEADBEEF;
        mem_rdata = 32'h00000000;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                mem_rdata <= mem[mem_addr];
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) begin
                        mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          disp_grants;
    int          first_kind;   // 0 none, 1 display, 2 cpu
    logic        cpu_granted;
    logic [10:0] next_addr;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        axi_aresetn = 1'b0;
        disp_req    = 1'b1;
        disp_addr   = 11'd0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = 11'd0;
        cpu_wdata   = 32'h0;
        cpu_wstrb   = 4'b0000;

        // Reset state (display requesting address 0 must still not hit).
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_disp_valid", {31'b0, disp_valid}, 32'd0);
        check_val("rst_disp_data", disp_data, 32'h0);
        check_val("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
        check_val("rst_cpu_rdata", cpu_rdata, 32'h0);
        check_val("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check_val("rst_mem_we", {28'b0, mem_we}, 32'd0);
        check_val("rst_mem_addr", {21'b0, mem_addr}, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'h0);
        disp_req    = 1'b0;
        axi_aresetn = 1'b1;
        step();

        // Display miss at address 5: fetch, then hit three cycles later.
        disp_req  = 1'b1;
        disp_addr = 11'd5;
        #1;
        check_val("miss_valid_t0", {31'b0, disp_valid}, 32'd0);
        check_val("miss_mem_en_t0", {31'b0, mem_en}, 32'd0);
        step();
        check_val("miss_mem_en_t1", {31'b0, mem_en}, 32'd1);
        check_val("miss_mem_addr_t1", {21'b0, mem_addr}, 32'd5);
        check_val("miss_mem_we_t1", {28'b0, mem_we}, 32'd0);
        step();
        check_val("miss_mem_en_t2", {31'b0, mem_en}, 32'd0);
        check_val("miss_valid_t2", {31'b0, disp_valid}, 32'd0);
        step();
        check_val("miss_valid_t3", {31'b0, disp_valid}, 32'd1);
        check_val("miss_data_t3", disp_data, 32'h41424344);
        step();
        check_val("hit_no_refetch", {31'b0, mem_en}, 32'd0);

        // CPU read of address 7 while the display hits.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'd7;
        #1;
        check_val("rd_mem_en_t0", {31'b0, mem_en}, 32'd0);
        step();
        check_val("rd_mem_en_t1", {31'b0, mem_en}, 32'd1);
        check_val("rd_mem_addr_t1", {21'b0, mem_addr}, 32'd7);
        check_val("rd_mem_we_t1", {28'b0, mem_we}, 32'd0);
        step();
        check_val("rd_ack_t2", {31'b0, cpu_ack}, 32'd0);
        step();
        check_val("rd_ack_t3", {31'b0, cpu_ack}, 32'd1);
        check_val("rd_rdata_t3", cpu_rdata, 32'hDEADBEEF);
        step();
        check_val("rd_ack_single", {31'b0, cpu_ack}, 32'd0);
        check_val("rd_no_regrant", {31'b0, mem_en}, 32'd0);
        check_val("rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 1'b0;
        step();
        check_val("rd_idle_mem_en", {31'b0, mem_en}, 32'd0);

        // CPU byte write to the cached address 5 updates the cache in place.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 11'd5;
        cpu_wdata = 32'h000000FF;
        cpu_wstrb = 4'b0001;
        step();
        check_val("wr_mem_en_t1", {31'b0, mem_en}, 32'd1);
        check_val("wr_mem_we_t1", {28'b0, mem_we}, 32'd1);
        check_val("wr_mem_wdata_t1", mem_wdata, 32'h000000FF);
        check_val("wr_mem_addr_t1", {21'b0, mem_addr}, 32'd5);
        check_val("wr_cache_old_t1", disp_data, 32'h41424344);
        step();
        check_val("wr_ack_t2", {31'b0, cpu_ack}, 32'd1);
        check_val("wr_cache_new", disp_data, 32'h414243FF);
        check_val("wr_cache_valid", {31'b0, disp_valid}, 32'd1);
        check_val("wr_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        check_val("wr_bram", mem[5], 32'h414243FF);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        step();
        check_val("wr_no_refetch", {31'b0, mem_en}, 32'd0);
        check_val("wr_ack_single", {31'b0, cpu_ack}, 32'd0);

        // disp_addr changes mid-fetch: in-flight fetch completes, then refetch.
        disp_addr = 11'd9;
        step();
        check_val("chg_mem_addr_t1", {21'b0, mem_addr}, 32'd9);
        disp_addr = 11'd10;
        step();
        step();
        check_val("chg_valid_t3", {31'b0, disp_valid}, 32'd0);
        check_val("chg_data_t3", disp_data, 32'h5A000009);
        step();
        check_val("chg_mem_en_t4", {31'b0, mem_en}, 32'd1);
        check_val("chg_mem_addr_t4", {21'b0, mem_addr}, 32'd10);
        step();
        step();
        check_val("chg_valid_t6", {31'b0, disp_valid}, 32'd1);
        check_val("chg_data_t6", disp_data, 32'h5A00000A);

        // Continuous display misses against a waiting CPU read.
        next_addr   = 11'd200;
        disp_addr   = next_addr;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 11'd7;
        disp_grants = 0;
        first_kind  = 0;
        cpu_granted = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            if (mem_en) begin
                if (mem_addr == 11'd7) begin
                    if (first_kind == 0) first_kind = 2;
                    cpu_granted = 1'b1;
                end else begin
                    if (first_kind == 0) first_kind = 1;
                    if (!cpu_granted) disp_grants++;
                end
            end
            if (cpu_ack) cpu_req = 1'b0;
            if (disp_valid) begin
                next_addr = next_addr + 11'd1;
                disp_addr = next_addr;
            end
        end
        check_val("arb_first_display", 32'(first_kind), 32'd1);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        check_val("arb_cpu_granted", {31'b0, cpu_granted}, 32'd1);
        check_val("arb_disp_before_cpu", 32'(disp_grants), 32'd8);
        check_val("arb_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
`else
        check_val("arb_cpu_starved", {31'b0, cpu_granted}, 32'd0);
        check_val("arb_disp_many", {31'b0, (disp_grants > 8)}, 32'd1);
`endif
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (5) step();

        // Reset asserted during CAPTURE of a CPU read.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'd7;
        step();
        check_val("rr_mem_en_t1", {31'b0, mem_en}, 32'd1);
        step();
        check_val("rr_ack_t2", {31'b0, cpu_ack}, 32'd0);
        disp_req    = 1'b1;
        disp_addr   = 11'd0;
        axi_aresetn = 1'b0;
        #1;
        check_val("rr_cpu_ack", {31'b0, cpu_ack}, 32'd0);
        check_val("rr_disp_valid", {31'b0, disp_valid}, 32'd0);
        check_val("rr_disp_data", disp_data, 32'h0);
        check_val("rr_cpu_rdata", cpu_rdata, 32'h0);
        check_val("rr_mem_en", {31'b0, mem_en}, 32'd0);
        check_val("rr_mem_addr", {21'b0, mem_addr}, 32'd0);
        check_val("rr_mem_wdata", mem_wdata, 32'h0);
        cpu_req = 1'b0;
        step();
        check_val("rr_ack_held", {31'b0, cpu_ack}, 32'd0);
        check_val("rr_mem_en_held", {31'b0, mem_en}, 32'd0);
        disp_req    = 1'b0;
        axi_aresetn = 1'b1;
        step();
        check_val("rr_ack_after", {31'b0, cpu_ack}, 32'd0);
        check_val("rr_mem_en_after", {31'b0, mem_en}, 32'd0);
        step();
        check_val("rr_ack_after2", {31'b0, cpu_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, VRAM word-address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 32, VRAM word width (four 8-bit glyph codes).
REQ-003 SHALL have parameter STARVE_MAX, default 8, maximum consecutive display grants while a CPU request waits.
REQ-004 SHALL have port axi_aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port axi_aresetn, input, 1 bit, reset, asynchronous assert, active-low.
REQ-006 SHALL have ports disp_req (input, 1) and disp_addr (input, ADDR_W): display fetch request and word address.
REQ-007 SHALL have ports disp_data (output, DATA_W) and disp_valid (output, 1): the cached display word and its hit flag.
REQ-008 SHALL have ports cpu_req, cpu_we (input, 1), cpu_addr (input, ADDR_W), cpu_wdata (input, DATA_W), cpu_wstrb (input, 4): CPU access request.
REQ-009 SHALL have ports cpu_ack (output, 1) and cpu_rdata (output, DATA_W): completion pulse and read data.
REQ-010 SHALL have ports mem_en (output, 1), mem_we (output, 4), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W): the single BRAM port, with 1-cycle read latency.

Function
REQ-011 SHALL hold a one-entry display cache: tag (ADDR_W bits), tag_valid, and data word; disp_data is the cached word and disp_valid = tag_valid & (tag == disp_addr), combinational.
REQ-012 SHALL raise a display miss when disp_req=1 and disp_valid=0.
REQ-013 SHALL implement the FSM IDLE -> ACCESS -> CAPTURE -> IDLE for reads, and IDLE -> ACCESS -> IDLE for CPU writes.
REQ-014 In IDLE SHALL choose a winner each cycle. A display miss wins over a pending cpu_req, except when REQ-027 applies. A CPU request is considered only when no ack is outstanding.
REQ-015 SHALL register mem_en, mem_we, mem_addr and mem_wdata on the grant edge, so they are visible only in ACCESS; in all other states mem_en=0 and mem_we=0.
REQ-016 For a display grant, SHALL in CAPTURE load the cache with tag<=granted address, data<=mem_rdata and tag_valid<=1; display miss-to-hit latency is 3 cycles.
REQ-017 For a CPU read, SHALL in CAPTURE register cpu_rdata<=mem_rdata and pulse cpu_ack for exactly one cycle, visible on the cycle after CAPTURE.
REQ-018 For a CPU write, SHALL drive mem_we=cpu_wstrb in ACCESS and pulse cpu_ack for one cycle on the cycle after ACCESS.
REQ-019 cpu_req and its qualifiers SHALL be held stable by the requester until cpu_ack; the arbiter SHALL NOT re-grant the same request in the cycle cpu_ack is high.
REQ-020 A CPU write whose address equals the tag while tag_valid=1 SHALL update the cached word byte-wise per cpu_wstrb in the same cycle as the BRAM write, keeping the cache coherent.
REQ-021 SHALL ignore a disp_addr change during ACCESS/CAPTURE; the in-flight fetch completes, and a new miss is evaluated in IDLE.
REQ-022 cpu_rdata SHALL hold its last value between reads.

Reset
REQ-023 axi_aresetn=0 SHALL immediately force state IDLE, tag_valid=0, tag=0, cached data=0, cpu_ack=0, cpu_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 and starve counter=0.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no cpu_ack; the requester re-issues it after reset.
REQ-025 While in reset, disp_valid SHALL be 0.

Configuration
REQ-026 The macro VRAM_ARB_STARVE_GUARD_EN SHALL control the starvation guard.
REQ-027 With VRAM_ARB_STARVE_GUARD_EN defined, a saturating counter SHALL count display grants made while cpu_req=1; when it equals STARVE_MAX, the next IDLE grant goes to the CPU, and the counter clears on every CPU grant.
REQ-028 Without VRAM_ARB_STARVE_GUARD_EN, display priority SHALL be strict and the counter logic SHALL be absent.

Verification
REQ-029 Reset, then disp_req=1, disp_addr=5 with mem[5]=0x41424344 -> mem_en high 1 cycle at addr 5, disp_valid=1 and disp_data=0x41424344 3 cycles after the request.
REQ-030 cpu_req read at addr 7 (mem[7]=0xDEADBEEF) with no display miss -> cpu_ack one pulse 3 cycles after grant, cpu_rdata=0xDEADBEEF.
REQ-031 Cache holding tag=5 and data 0x41424344, then CPU write 0x000000FF with wstrb=0001 to addr 5 -> BRAM written, disp_data=0x414243FF with no refetch, cpu_ack 2 cycles after grant.
REQ-032 Simultaneous display miss and cpu_req -> display granted first, then CPU; with the guard enabled and continuous misses, the CPU is granted after exactly 8 display grants; without the guard, the CPU is never granted.
REQ-033 axi_aresetn pulsed low during CAPTURE of a CPU read -> no cpu_ack, disp_valid=0, all outputs at reset values.
